// File: rtl/sdram_init_refresh_seq.sv
// SDRAM power-up init sequencer (PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE)
// followed by a periodic refresh request timer with a req/ack pending counter.
module sdram_init_refresh_seq #(
    parameter int          T_POWERUP = 10000,
    parameter int          T_RP      = 2,
    parameter int          T_RC      = 7,
    parameter int          T_MRD     = 2,
    parameter int          N_REF     = 8,
    parameter int          T_REFI    = 780,
    parameter logic [12:0] MODE_WORD = 13'h0030
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ref_ack,
    output logic [3:0]  cmd,
    output logic [12:0] addr,
    output logic [1:0]  ba,
    output logic        cke,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_overflow
);
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_AREF    = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    localparam logic [2:0] S_PWR   = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_PRE_W = 3'd2;
    localparam logic [2:0] S_REF   = 3'd3;
    localparam logic [2:0] S_REF_W = 3'd4;
    localparam logic [2:0] S_MRS   = 3'd5;
    localparam logic [2:0] S_MRS_W = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    // Terminal counts: the wait counter restarts at 0 on the cycle each command is on the bus.
    localparam logic [15:0] PWR_M1  = 16'(T_POWERUP - 1);
    localparam logic [15:0] RP_M1   = 16'(T_RP - 1);
    localparam logic [15:0] RC_M1   = 16'(T_RC - 1);
    localparam logic [15:0] MRD_M1  = 16'(T_MRD - 1);
    localparam logic [15:0] REFI_M1 = 16'(T_REFI - 1);
    localparam logic [3:0]  NREF    = 4'(N_REF);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [3:0]  ref_cnt;
    logic [15:0] tmr;
    logic [2:0]  pending;
    logic [2:0]  pend_nxt;
    logic        expire;
    logic        ovf_set;

    assign expire = (state == S_DONE) && (tmr == REFI_M1);

    // Timer expiry and ack cancel each other; acks are only honoured after init.
    always_comb begin
        pend_nxt = pending;
        ovf_set  = 1'b0;
        if (state == S_DONE) begin
            if (expire && !ref_ack) begin
                if (pending == 3'd7) ovf_set = 1'b1;
                else pend_nxt = pending + 3'd1;
            end else if (!expire && ref_ack && (pending != 3'd0)) begin
                pend_nxt = pending - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_PWR;
            cnt          <= '0;
            ref_cnt      <= '0;
            tmr          <= '0;
            pending      <= '0;
            cmd          <= CMD_INHIBIT;
            addr         <= '0;
            ba           <= '0;
            cke          <= 1'b0;
            init_done    <= 1'b0;
            ref_req      <= 1'b0;
            ref_overflow <= 1'b0;
        end else begin
            cmd  <= CMD_NOP;
            addr <= '0;
            ba   <= '0;
            cke  <= 1'b1;
            case (state)
                S_PWR: begin
                    if (cnt == PWR_M1) begin
                        state <= S_PRE;
                        cmd   <= CMD_PRE;
                        addr  <= 13'h0400;
                        cnt   <= '0;
                    end else begin
                        cmd <= CMD_INHIBIT;
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PRE, S_PRE_W: begin
                    if (cnt == RP_M1) begin
                        state   <= S_REF;
                        cmd     <= CMD_AREF;
                        ref_cnt <= 4'd1;
                        cnt     <= '0;
                    end else begin
                        state <= S_PRE_W;
                        cnt   <= cnt + 16'd1;
                    end
                end
                S_REF, S_REF_W: begin
                    if (cnt == RC_M1) begin
                        cnt <= '0;
                        if (ref_cnt == NREF) begin
                            state <= S_MRS;
                            cmd   <= CMD_LMR;
                            addr  <= MODE_WORD;
                        end else begin
                            state   <= S_REF;
                            cmd     <= CMD_AREF;
                            ref_cnt <= ref_cnt + 4'd1;
                        end
                    end else begin
                        state <= S_REF_W;
                        cnt   <= cnt + 16'd1;
                    end
                end
                S_MRS, S_MRS_W: begin
                    if (cnt == MRD_M1) begin
                        state     <= S_DONE;
                        init_done <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        state <= S_MRS_W;
                        cnt   <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    // Free-running interval: restarts only on expiry to keep the average rate.
                    tmr <= expire ? 16'd0 : tmr + 16'd1;
                end
                default: state <= S_PWR;
            endcase
            pending <= pend_nxt;
            ref_req <= (pend_nxt != 3'd0);
            if (ovf_set) ref_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_init_refresh_seq.sv
// Directed bench: init command timing, reset behaviour, refresh handshake and overflow.
module tb_sdram_init_refresh_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ref_ack, ref_ack2;
    logic [3:0]  cmd, cmd2;
    logic [12:0] addr, addr2;
    logic [1:0]  ba, ba2;
    logic        cke, cke2, init_done, init_done2;
    logic        ref_req, ref_req2, ref_overflow, ref_overflow2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sdram_init_refresh_seq #(
        .T_POWERUP(10), .T_RP(2), .T_RC(4), .T_MRD(2), .N_REF(2), .T_REFI(5), .MODE_WORD(13'h0030)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ref_ack(ref_ack), .cmd(cmd), .addr(addr), .ba(ba),
        .cke(cke), .init_done(init_done), .ref_req(ref_req), .ref_overflow(ref_overflow)
    );

    sdram_init_refresh_seq #(
        .T_POWERUP(10), .T_RP(2), .T_RC(4), .T_MRD(2), .N_REF(2), .T_REFI(20), .MODE_WORD(13'h0030)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ref_ack(ref_ack2), .cmd(cmd2), .addr(addr2), .ba(ba2),
        .cke(cke2), .init_done(init_done2), .ref_req(ref_req2), .ref_overflow(ref_overflow2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [3:0] exp_cmd(input int n);
        if (n <= 9) return 4'b1111;
        if (n == 10) return 4'b0010;
        if (n == 12 || n == 16) return 4'b0001;
        if (n == 20) return 4'b0000;
        return 4'b0111;
    endfunction

    function automatic logic [12:0] exp_addr(input int n);
        if (n == 10) return 13'h0400;
        if (n == 20) return 13'h0030;
        return 13'h0000;
    endfunction

    task automatic check_init_cycle();
        check("cmd", 16'(cmd), 16'(exp_cmd(cyc)));
        check("addr", 16'(addr), 16'(exp_addr(cyc)));
        check("ba", 16'(ba), 16'd0);
        check("cke", 16'(cke), 16'd1);
        check("init_done", 16'(init_done), 16'(cyc >= 22));
        check("ref_req_init", 16'(ref_req), 16'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ref_ack  = 1'b0;
        ref_ack2 = 1'b0;

        repeat (3) step();
        check("rst_cmd", 16'(cmd), 16'hf);
        check("rst_addr", 16'(addr), 16'd0);
        check("rst_cke", 16'(cke), 16'd0);
        check("rst_init_done", 16'(init_done), 16'd0);
        check("rst_ref_req", 16'(ref_req), 16'd0);
        check("rst_ovf", 16'(ref_overflow), 16'd0);

        // First pass, interrupted by reset at cycle 14
        rst_n = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            check_init_cycle();
        end
        rst_n = 1'b0;
        step();
        check("midrst_cmd", 16'(cmd), 16'hf);
        check("midrst_cke", 16'(cke), 16'd0);
        check("midrst_init_done", 16'(init_done), 16'd0);
        check("midrst_cmd2", 16'(cmd2), 16'hf);

        // Full pass; ack held high during init must be ignored
        rst_n   = 1'b1;
        ref_ack = 1'b1;
        cyc     = 0;
        for (int n = 1; n <= 22; n++) begin
            step();
            check_init_cycle();
        end
        ref_ack = 1'b0;
        check("init_done2", 16'(init_done2), 16'd1);

        // First expiry 5 cycles after init_done
        for (int n = 23; n <= 27; n++) begin
            step();
            check("ref_req_first", 16'(ref_req), 16'(cyc >= 27));
            check("cmd_done", 16'(cmd), 16'h7);
        end
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        check("ack_clear", 16'(ref_req), 16'd0);
        for (int n = 29; n <= 32; n++) begin
            step();
            check("ref_req_second", 16'(ref_req), 16'(cyc >= 32));
        end

        // Pending=1, ack lands on the expiry edge at cycle 37
        while (cyc < 36) step();
        check("pre_simul_req", 16'(ref_req), 16'd1);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        check("simul_req", 16'(ref_req), 16'd1);
        check("simul_ovf", 16'(ref_overflow), 16'd0);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        check("simul_pending_one", 16'(ref_req), 16'd0);

        // Overflow on dut2 (T_REFI=20): expiries at 42, 62, ..., 182
        while (cyc < 41) step();
        check("ovf_req_before", 16'(ref_req2), 16'd0);
        step();
        check("ovf_req_first", 16'(ref_req2), 16'd1);
        while (cyc < 162) step();
        check("ovf_seven_req", 16'(ref_req2), 16'd1);
        check("ovf_seven_flag", 16'(ref_overflow2), 16'd0);
        while (cyc < 182) step();
        check("ovf_eight_req", 16'(ref_req2), 16'd1);
        check("ovf_eight_flag", 16'(ref_overflow2), 16'd1);
        ref_ack2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("ovf_drain_req", 16'(ref_req2), 16'(k < 7));
        end
        ref_ack2 = 1'b0;
        check("ovf_sticky", 16'(ref_overflow2), 16'd1);
        step();
        check("ovf_ack_idle_req", 16'(ref_req2), 16'd0);
        check("ovf_sticky2", 16'(ref_overflow2), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
